config_rw_register_file: RTL
============================

CONFIG_RW_REGISTER_FILE -- requirements
Module: config_rw_register_file

Interface
REQ-001 SHALL have parameter NUM_RW, default 4, number of read/write registers, legal range 1 or more.
REQ-002 SHALL have parameter NUM_RO, default 4, number of read-only registers, legal range 0 or more.
REQ-003 SHALL have parameter DATA_BITS, default 32, register width, a multiple of 8.
REQ-004 SHALL have parameter ADDR_BITS, default 8, register-index address width; elaboration SHALL fail if NUM_RW+NUM_RO > 2^ADDR_BITS.
REQ-005 SHALL have parameter RW_RESET, default all zero, packed NUM_RW x DATA_BITS reset values, with register i at bits [i*DATA_BITS +: DATA_BITS].
REQ-006 SHALL have port clk, input, 1 bit, clock; all state on rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, reset: synchronous, active-low.
REQ-008 SHALL have ports read_valid (in, 1), read_ready (out, 1) and read_addr (in, ADDR_BITS): the read request channel.
REQ-009 SHALL have ports resp_valid (out, 1), resp_ready (in, 1), resp_data (out, DATA_BITS) and resp_error (out, 1): the read response channel.
REQ-010 SHALL have ports write_valid (in, 1), write_ready (out, 1), write_addr (in, ADDR_BITS), write_data (in, DATA_BITS) and write_strb (in, DATA_BITS/8): the write request channel.
REQ-011 SHALL have ports wresp_valid (out, 1), wresp_ready (in, 1) and wresp_error (out, 1): the write response channel.
REQ-012 SHALL have port ro_values, input, NUM_RO x DATA_BITS: status values sampled on a read.
REQ-013 SHALL have port rw_values, output, NUM_RW x DATA_BITS: current register contents.
REQ-014 SHALL have port write_pulse, output, NUM_RW bits: bit i high for one cycle when register i is written.

Function
REQ-015 SHALL map addresses 0..NUM_RW-1 to the RW registers and NUM_RW..NUM_RW+NUM_RO-1 to RO entry (addr-NUM_RW); every other address SHALL be unmapped.
REQ-016 SHALL run the read and write channels as independent two-state FSMs (IDLE, RESP), with at most one outstanding transaction per channel.
REQ-017 Read channel: read_ready=1 only in IDLE; a read_valid&&read_ready handshake at cycle t SHALL register resp_data/resp_error and assert resp_valid at t+1, then move to RESP.
REQ-018 In RESP, resp_data, resp_error and resp_valid SHALL stay stable until resp_valid&&resp_ready, then the FSM SHALL return to IDLE in the next cycle (no back-to-back accept in the same cycle).
REQ-019 A read of an unmapped address SHALL return resp_data=0 and resp_error=1; mapped reads SHALL return resp_error=0.
REQ-020 Write channel: write_ready=1 only in IDLE; a handshake at cycle t SHALL update the mapped RW register bytes where write_strb=1 at t+1, raise write_pulse[i] for cycle t+1 only, and assert wresp_valid at t+1.
REQ-021 A write to an RO or unmapped address SHALL leave all registers unchanged, pulse nothing, and return wresp_error=1; write_strb=0 to an RW register SHALL return wresp_error=0 with write_pulse still asserted.
REQ-022 wresp_valid/wresp_error SHALL hold until wresp_ready, then return to IDLE.
REQ-023 A read and a write to the same RW register accepted in the same cycle SHALL return the pre-write value.
REQ-024 rw_values SHALL reflect the register contents combinationally from the flops (updates visible at t+1).

Reset
REQ-025 While rst_n=0 at a clock edge: both FSMs SHALL go to IDLE; resp_valid, wresp_valid and write_pulse SHALL be 0; resp_data, resp_error and wresp_error SHALL be 0; RW registers SHALL equal RW_RESET.
REQ-026 A reset asserted mid-transaction SHALL drop the pending response without completing it; the next transaction after reset SHALL behave normally.

Verification
REQ-027 Reset with RW_RESET reg1=0xA5A5_0001 -> read addr 1 returns 0xA5A5_0001, error 0, resp_valid one cycle after accept.
REQ-028 Write 0xDEADBEEF with strb 4'b0101 to addr 0, which holds 0 -> rw_values[0]=0x00AD00EF, write_pulse=4'b0001 for exactly one cycle, wresp_error=0.
REQ-029 NUM_RW=4, ro_values[1]=0x1234 -> read addr 5 returns 0x1234; write to addr 5 returns wresp_error=1 with no register change or pulse.
REQ-030 Read addr 200 -> resp_data=0, resp_error=1; resp_ready held low for 3 cycles -> response stable and read_ready=0 throughout.
REQ-031 Simultaneous write 0x55 and read to addr 2, which holds 0x11 -> read returns 0x11, and a following read returns 0x55.
REQ-032 Assert rst_n=0 while wresp_valid=1 -> wresp_valid=0 after the edge, registers equal RW_RESET, write_ready=1 after release.

Source files
------------

// File: rtl/config_rw_register_file.sv
// -----------------------------------------------------------------------------
// config_rw_register_file
//
// Purpose:
//   A small configuration and status register file with independent read and
//   write channels. Each channel carries at most one outstanding transaction
//   and uses valid/ready handshakes.
//
//   Address map (register index, not byte address):
//     0 .. NUM_RW-1                 read/write registers
//     NUM_RW .. NUM_RW+NUM_RO-1     read-only status inputs (ro_values)
//     anything else                 unmapped: reads return 0 with an error,
//                                   writes are dropped with an error
//
// Ports:
//   clk, rst_n       clock; synchronous active-low reset
//   read_*           read request channel (valid/ready, index)
//   resp_*           read response channel (valid/ready, data, error)
//   write_*          write request channel (valid/ready, index, data, byte strobes)
//   wresp_*          write response channel (valid/ready, error)
//   ro_values        packed status inputs; entry j at [j*DATA_BITS +: DATA_BITS]
//   rw_values        packed register contents; register i at [i*DATA_BITS +: DATA_BITS]
//   write_pulse      one-cycle strobe per register, raised when it is written
// -----------------------------------------------------------------------------
module config_rw_register_file #(
  parameter int NUM_RW    = 4,
  parameter int NUM_RO    = 4,
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 8,
  parameter logic [NUM_RW*DATA_BITS-1:0] RW_RESET = '0,
  // With no status registers the input keeps a minimum width of one entry.
  localparam int RO_SLOTS = (NUM_RO > 0) ? NUM_RO : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,

  input  logic                          read_valid,
  output logic                          read_ready,
  input  logic [ADDR_BITS-1:0]          read_addr,

  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_BITS-1:0]          resp_data,
  output logic                          resp_error,

  input  logic                          write_valid,
  output logic                          write_ready,
  input  logic [ADDR_BITS-1:0]          write_addr,
  input  logic [DATA_BITS-1:0]          write_data,
  input  logic [DATA_BITS/8-1:0]        write_strb,

  output logic                          wresp_valid,
  input  logic                          wresp_ready,
  output logic                          wresp_error,

  input  logic [RO_SLOTS*DATA_BITS-1:0] ro_values,
  output logic [NUM_RW*DATA_BITS-1:0]   rw_values,
  output logic [NUM_RW-1:0]             write_pulse
);

  localparam int STRB_BITS = DATA_BITS / 8;

  // Elaboration-time parameter legality checks.
  if (NUM_RW < 1) begin : g_bad_num_rw
    $error("config_rw_register_file: NUM_RW must be at least 1");
  end
  if (NUM_RO < 0) begin : g_bad_num_ro
    $error("config_rw_register_file: NUM_RO must not be negative");
  end
  if ((DATA_BITS < 8) || (DATA_BITS % 8 != 0)) begin : g_bad_data_bits
    $error("config_rw_register_file: DATA_BITS must be a non-zero multiple of 8");
  end
  if ((64'(NUM_RW) + 64'(NUM_RO)) > (64'd1 << ADDR_BITS)) begin : g_bad_addr_bits
    $error("config_rw_register_file: NUM_RW+NUM_RO exceeds 2^ADDR_BITS");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } chan_state_t;

  logic [DATA_BITS-1:0] rw_regs [NUM_RW];

  chan_state_t          rd_state, rd_state_next;
  chan_state_t          wr_state, wr_state_next;

  logic                 rd_fire;
  logic                 wr_fire;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_err;
  logic [NUM_RW-1:0]    wr_hit;

  // Packed view of the register array.
  for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_rw_out
    assign rw_values[gi*DATA_BITS +: DATA_BITS] = rw_regs[gi];
  end

  assign rd_fire = read_valid && read_ready;
  assign wr_fire = write_valid && write_ready;

  // ---------------------------------------------------------------------------
  // Read address decode and data select. The mux reads the flops as they are
  // this cycle, so a write accepted in the same cycle is not yet visible.
  // Index casts cannot alias because the map fits in the address space.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b1;
    for (int i = 0; i < NUM_RW; i++) begin
      if (read_addr == ADDR_BITS'(i)) begin
        rd_data = rw_regs[i];
        rd_err  = 1'b0;
      end
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (read_addr == ADDR_BITS'(NUM_RW + j)) begin
        rd_data = ro_values[j*DATA_BITS +: DATA_BITS];
        rd_err  = 1'b0;
      end
    end
  end

  // Write decode: one-hot over RW registers; all-zero means RO or unmapped.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (write_addr == ADDR_BITS'(i)) begin
        wr_hit[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state <= IDLE;
    end else begin
      rd_state <= rd_state_next;
    end
  end

  always_comb begin
    rd_state_next = rd_state;
    read_ready    = 1'b0;
    resp_valid    = 1'b0;
    case (rd_state)
      IDLE: begin
        read_ready = 1'b1;
        if (read_valid) begin
          rd_state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        // Return to IDLE only after the response is taken; no new request is
        // accepted in the same cycle.
        if (resp_ready) begin
          rd_state_next = IDLE;
        end
      end
      default: rd_state_next = IDLE;
    endcase
  end

  // Response payload is captured at accept and held until the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else if (rd_fire) begin
      resp_data  <= rd_data;
      resp_error <= rd_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Write channel FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state <= IDLE;
    end else begin
      wr_state <= wr_state_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state;
    write_ready   = 1'b0;
    wresp_valid   = 1'b0;
    case (wr_state)
      IDLE: begin
        write_ready = 1'b1;
        if (write_valid) begin
          wr_state_next = RESP;
        end
      end
      RESP: begin
        wresp_valid = 1'b1;
        if (wresp_ready) begin
          wr_state_next = IDLE;
        end
      end
      default: wr_state_next = IDLE;
    endcase
  end

  // Write response error and per-register strobes. The pulse fires even with
  // an all-zero strobe, so software can use a zero-strobe write as a trigger.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wresp_error <= 1'b0;
      write_pulse <= '0;
    end else begin
      write_pulse <= wr_fire ? wr_hit : '0;
      if (wr_fire) begin
        wresp_error <= ~|wr_hit;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register storage with byte-lane enables
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RW; i++) begin
        rw_regs[i] <= RW_RESET[i*DATA_BITS +: DATA_BITS];
      end
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (wr_hit[i]) begin
          for (int b = 0; b < STRB_BITS; b++) begin
            if (write_strb[b]) begin
              rw_regs[i][b*8 +: 8] <= write_data[b*8 +: 8];
            end
          end
        end
      end
    end
  end

endmodule
